knn_pe_lane: RTL and testbench
==============================

// Module: knn_pe_lane
// PURPOSE
// - One classification lane of the KNN accelerator: a KNN processing element plus its positive-vote counter.
// - Classifies a 32-bit sample against a loadable training set using k-nearest neighbours (Manhattan distance).
// - Counts positive classifications until re-initialised.
// - Four lanes run in parallel in the accelerator core; the core sums the counts and compares the total to a threshold.
// PARAMETERS
// - N_TRAIN   16   number of training vectors held in the lane (2..256)
// - CNT_W     11   width of positive-classification counter
// PORTS
// - CLK                    in   1   single clock, all logic on rising edge
// - RESETn                 in   1   reset, synchronous, active-high (name kept per codebase)
// - control                in   2   k select: 00->k=1, 01->k=3, 10->k=5, 11->k=7
// - sample_data            in   32  four unsigned 8-bit features, f0=[7:0] .. f3=[31:24]
// - classify_enable        in   1   1-cycle start pulse; sample_data/control sampled on same edge
// - train_we               in   1   training-memory write strobe
// - train_addr             in   8   training-vector index (writes with addr >= N_TRAIN ignored)
// - train_data             in   32  training features, same packing as sample_data
// - train_label            in   1   training label (1 = stress)
// - init                   in   1   clears vote counter
// - sample_classification  out  1   result of last classification
// - classify_sample_done   out  1   1-cycle pulse, result valid
// - count                  out  CNT_W  number of done pulses with classification=1
// BEHAVIOUR
// - Reset (RESETn=1 at edge): FSM->IDLE; sample_classification, classify_sample_done, count = 0.
//   Training memory is not cleared. Reset mid-classification aborts it; no done pulse is issued.
// - Training writes are accepted only in IDLE; train_we in any other state is ignored.
// - FSM states: IDLE -> COMPARE -> VOTE -> DONE -> IDLE.
// - IDLE: classify_enable=1 latches sample and k, clears the k-best list (all entries invalid), idx=0, goes to COMPARE.
// - COMPARE: one training vector per cycle.
//   - dist = sum over i of |f_i(sample) - f_i(train[idx])|, 10-bit unsigned, max 1020.
//   - Insert into ascending sorted list of k entries (dist, label) if the list is not full or dist < worst entry.
//   - Equal distance never displaces an existing entry, so a lower idx wins ties.
//   - After idx = N_TRAIN-1, go to VOTE.
// - VOTE: ones = labels=1 among the k entries; result = (ones > k/2). Go to DONE.
// - DONE: sample_classification <= result; classify_sample_done = 1 for this single cycle; next state IDLE.
// - Latency:
//   - Enable sampled at edge E0; done is high in the cycle after edge E0+N_TRAIN+1.
//   - Classifications are back-to-back capable: enable is legal again in the cycle after done.
// - classify_enable outside IDLE is ignored.
// - sample_classification holds its value until the next DONE.
// - Counter:
//   - init=1 -> count <= 0 (priority over increment).
//   - Else, classify_sample_done && sample_classification -> count+1, saturating at 2^CNT_W-1.
// TESTING
// - Load train[0..15] with all features 0x00 and label 1 except train[5]=0x10101010 label 0. Sample 0x10101010, k=1
//   -> done after 18 edges, classification 0, count stays 0.
// - Same training set, sample 0x00000000, k=7 -> classification 1; after done, count=1.
// - Tie: train[2] and train[9] both at distance 4, labels 0 and 1, all others distance >=100, k=1
//   -> classification 0 (lower idx wins).
// - k=3 with nearest labels {1,0,1} -> 1; k=5 with nearest labels {1,1,0,0,0} -> 0.
// - Reset asserted during COMPARE -> no done pulse, outputs 0; pulse init -> count 0.
//   2050 positive classifications -> count saturates at 2047.
// - classify_enable re-pulsed during COMPARE, and train_we during COMPARE -> both ignored; result unchanged.

Source files
------------

// File: rtl/knn_pe_lane_if.sv
// Request/result bundle for one KNN lane: training writes, classify start, and the result/vote count.
interface knn_pe_lane_if #(
  parameter int CNT_W = 11
);
  logic [1:0]       control;
  logic [31:0]      sample_data;
  logic             classify_enable;
  logic             train_we;
  logic [7:0]       train_addr;
  logic [31:0]      train_data;
  logic             train_label;
  logic             init;
  logic             sample_classification;
  logic             classify_sample_done;
  logic [CNT_W-1:0] count;

  modport master (
    output control, sample_data, classify_enable,
    output train_we, train_addr, train_data, train_label, init,
    input  sample_classification, classify_sample_done, count
  );

  modport slave (
    input  control, sample_data, classify_enable,
    input  train_we, train_addr, train_data, train_label, init,
    output sample_classification, classify_sample_done, count
  );
endinterface

// File: rtl/knn_pe_lane.sv
// KNN lane: scans N_TRAIN stored vectors (one per cycle), keeps a sorted k-best list, majority-votes,
// and counts positive results. Done pulses N_TRAIN+2 cycles after the start pulse; starts outside IDLE are dropped.
module knn_pe_lane #(
  parameter int N_TRAIN = 16,
  parameter int CNT_W   = 11
) (
  input  logic          CLK,
  input  logic          RESETn,
  knn_pe_lane_if.slave  bus
);

  localparam int IDX_W = (N_TRAIN > 1) ? $clog2(N_TRAIN) : 1;
  localparam int K_MAX = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_VOTE    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      smp_q;
  logic [2:0]       k_q;
  logic [IDX_W-1:0] idx_q;
  logic [9:0]       dist_q [K_MAX];
  logic [9:0]       dist_d [K_MAX];
  logic [K_MAX-1:0] lab_q, lab_d;
  logic [K_MAX-1:0] vld_q, vld_d;
  logic             cls_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      mem_dat_q [N_TRAIN];
  logic             mem_lab_q [N_TRAIN];

  logic             train_wr;
  logic [31:0]      cur_dat;
  logic             cur_lab;
  logic [9:0]       cur_dist;
  logic [K_MAX-1:0] take;
  logic [2:0]       ones;
  logic             vote_res;
  logic             done;

  function automatic logic [9:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
  endfunction

  // Training memory is deliberately left out of reset.
  assign train_wr = (state_q == S_IDLE) && bus.train_we &&
                    ({24'd0, bus.train_addr} < 32'(N_TRAIN));

  always_ff @(posedge CLK) begin
    if (train_wr) begin
      mem_dat_q[bus.train_addr[IDX_W-1:0]] <= bus.train_data;
      mem_lab_q[bus.train_addr[IDX_W-1:0]] <= bus.train_label;
    end
  end

  assign cur_dat  = mem_dat_q[idx_q];
  assign cur_lab  = mem_lab_q[idx_q];
  assign cur_dist = abs_diff(smp_q[7:0],   cur_dat[7:0])   +
                    abs_diff(smp_q[15:8],  cur_dat[15:8])  +
                    abs_diff(smp_q[23:16], cur_dat[23:16]) +
                    abs_diff(smp_q[31:24], cur_dat[31:24]);

  // take[] is a thermometer from the insertion slot up to k-1; strict < keeps earlier ties in place.
  always_comb begin
    take = '0;
    for (int j = 0; j < K_MAX; j++) begin
      take[j] = (3'(j) < k_q) && (!vld_q[j] || (cur_dist < dist_q[j]));
    end
    dist_d = dist_q;
    lab_d  = lab_q;
    vld_d  = vld_q;
    for (int j = K_MAX - 1; j >= 1; j--) begin
      if (take[j]) begin
        if (take[j-1]) begin
          dist_d[j] = dist_q[j-1];
          lab_d[j]  = lab_q[j-1];
          vld_d[j]  = vld_q[j-1];
        end else begin
          dist_d[j] = cur_dist;
          lab_d[j]  = cur_lab;
          vld_d[j]  = 1'b1;
        end
      end
    end
    if (take[0]) begin
      dist_d[0] = cur_dist;
      lab_d[0]  = cur_lab;
      vld_d[0]  = 1'b1;
    end
  end

  // k = 2*control+1, so "more than k/2" is simply ones > control.
  always_comb begin
    ones = '0;
    for (int j = 0; j < K_MAX; j++) begin
      if ((3'(j) < k_q) && vld_q[j] && lab_q[j]) ones = ones + 3'd1;
    end
    vote_res = (ones > {1'b0, k_q[2:1]});
  end

  always_ff @(posedge CLK) begin
    if (RESETn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.classify_enable) state_d = S_COMPARE;
      S_COMPARE: if (idx_q == IDX_W'(N_TRAIN - 1)) state_d = S_VOTE;
      S_VOTE:    state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESETn) begin
      smp_q <= '0;
      k_q   <= '0;
      idx_q <= '0;
      vld_q <= '0;
      cls_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.classify_enable) begin
            smp_q <= bus.sample_data;
            k_q   <= {bus.control, 1'b1};
            idx_q <= '0;
            vld_q <= '0;
          end
        end
        S_COMPARE: begin
          idx_q  <= idx_q + 1'b1;
          dist_q <= dist_d;
          lab_q  <= lab_d;
          vld_q  <= vld_d;
        end
        S_VOTE:  cls_q <= vote_res;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.init)                         cnt_d = '0;
    else if (done && cls_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESETn) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.sample_classification = cls_q;
  assign bus.classify_sample_done  = done;
  assign bus.count                 = cnt_q;

endmodule

// File: tb/tb_knn_pe_lane.sv
// Randomised and directed checks of knn_pe_lane against a brute-force nearest-neighbour model.
module tb_knn_pe_lane;
  localparam int N  = 16;
  localparam int CW = 11;
  localparam int CNT_SAT = (1 << CW) - 1;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knn_pe_lane_if #(.CNT_W(CW)) bus();
  knn_pe_lane #(.N_TRAIN(N), .CNT_W(CW)) dut (.CLK(clk), .RESETn(rst), .bus(bus));

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_dat [N];
  logic        m_lab [N];
  int          m_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sort-free selection: pick the k smallest distances, lowest index first on ties.
  function automatic logic model_cls(input logic [31:0] s, input logic [1:0] ksel);
    int  d [N];
    bit  used [N];
    int  k = 2 * int'(ksel) + 1;
    int  ones = 0;
    int  best;
    for (int i = 0; i < N; i++) begin
      d[i] = 0;
      used[i] = 0;
      for (int f = 0; f < 4; f++) begin
        int a = int'(s[8*f +: 8]);
        int b = int'(m_dat[i][8*f +: 8]);
        d[i] += (a > b) ? a - b : b - a;
      end
    end
    for (int r = 0; r < k && r < N; r++) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
      used[best] = 1;
      ones += int'(m_lab[best]);
    end
    return ones > k / 2;
  endfunction

  task automatic write_train(input int addr, input logic [31:0] dat, input logic lab);
    bus.train_we    = 1'b1;
    bus.train_addr  = 8'(addr);
    bus.train_data  = dat;
    bus.train_label = lab;
    step();
    bus.train_we = 1'b0;
    if (addr < N) begin
      m_dat[addr] = dat;
      m_lab[addr] = lab;
    end
  endtask

  // Leaves the bench in the done cycle; lat = -1 when no done pulse arrives.
  task automatic run_classify(input logic [31:0] s, input logic [1:0] ks,
                              output int lat, output logic cls, output logic exp);
    exp = model_cls(s, ks);
    bus.sample_data     = s;
    bus.control         = ks;
    bus.classify_enable = 1'b1;
    step();
    bus.classify_enable = 1'b0;
    lat = 0;
    while (bus.classify_sample_done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (lat >= 40) lat = -1;
    cls = bus.sample_classification;
    if (lat >= 0 && exp && m_cnt < CNT_SAT) m_cnt++;
  endtask

  task automatic load_spec_set();
    for (int i = 0; i < N; i++) write_train(i, 32'h0, 1'b1);
    write_train(5, 32'h10101010, 1'b0);
    write_train(21, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_cnt = 0;
    n_total++; if (bus.classify_sample_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.classify_sample_done); else n_pass++;
    n_total++; if (bus.sample_classification !== 1'b0) $display("FAIL reset_cls got=%b exp=0", bus.sample_classification); else n_pass++;
    n_total++; if (bus.count !== 11'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_k1_nearest();
    int lat; logic cls, exp;
    load_spec_set();
    run_classify(32'h10101010, 2'b00, lat, cls, exp);
    n_total++; if (lat !== LAT) $display("FAIL k1_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
    n_total++; if (cls !== 1'b0 || exp !== 1'b0) $display("FAIL k1_cls got=%b model=%b exp=0", cls, exp); else n_pass++;
    step();
    n_total++; if (bus.count !== 11'd0) $display("FAIL k1_count got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_k7_majority();
    int lat; logic cls, exp;
    run_classify(32'h0, 2'b11, lat, cls, exp);
    n_total++; if (cls !== 1'b1 || exp !== 1'b1) $display("FAIL k7_cls got=%b model=%b exp=1", cls, exp); else n_pass++;
    step();
    n_total++; if (bus.count !== 11'd1) $display("FAIL k7_count got=%0d exp=1", bus.count); else n_pass++;
  endtask

  task automatic test_tie();
    int lat; logic cls, exp;
    for (int i = 0; i < N; i++) write_train(i, 32'h40404040, 1'b1);
    write_train(2, 32'h01010101, 1'b0);
    write_train(9, 32'h00000004, 1'b1);
    run_classify(32'h0, 2'b00, lat, cls, exp);
    step();
    n_total++; if (cls !== 1'b0 || exp !== 1'b0) $display("FAIL tie_cls got=%b model=%b exp=0", cls, exp); else n_pass++;
  endtask

  task automatic test_k3_k5();
    int lat; logic cls, exp;
    for (int i = 0; i < N; i++) write_train(i, 32'h000000C8, 1'b0);
    write_train(14, 32'd1, 1'b1);
    write_train(6,  32'd2, 1'b0);
    write_train(1,  32'd3, 1'b1);
    run_classify(32'h0, 2'b01, lat, cls, exp);
    step();
    n_total++; if (cls !== 1'b1 || exp !== 1'b1) $display("FAIL k3_cls got=%b model=%b exp=1", cls, exp); else n_pass++;
    for (int i = 0; i < N; i++) write_train(i, 32'h000000C8, 1'b1);
    write_train(15, 32'd1, 1'b1);
    write_train(10, 32'd2, 1'b1);
    write_train(3,  32'd3, 1'b0);
    write_train(7,  32'd4, 1'b0);
    write_train(0,  32'd5, 1'b0);
    run_classify(32'h0, 2'b10, lat, cls, exp);
    step();
    n_total++; if (cls !== 1'b0 || exp !== 1'b0) $display("FAIL k5_cls got=%b model=%b exp=0", cls, exp); else n_pass++;
  endtask

  // Narrow feature range forces many distance ties; consecutive runs are back-to-back.
  task automatic test_random(input bit narrow);
    int lat; logic cls, exp;
    logic [31:0] v;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < N; i++) begin
        for (int f = 0; f < 4; f++) v[8*f +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
        write_train(i, v, 1'($urandom));
      end
      for (int t = 0; t < 8; t++) begin
        for (int f = 0; f < 4; f++) v[8*f +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
        run_classify(v, 2'($urandom), lat, cls, exp);
        n_total++; if (lat !== LAT || cls !== exp)
          $display("FAIL rand_cls sample=%h lat=%0d cls=%b exp_lat=%0d exp_cls=%b", v, lat, cls, LAT, exp);
        else n_pass++;
        step();
        n_total++; if (bus.count !== CW'(m_cnt)) $display("FAIL rand_count got=%0d exp=%0d", bus.count, m_cnt); else n_pass++;
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat; logic cls, exp;
    load_spec_set();
    exp = model_cls(32'h10101010, 2'b00);
    bus.sample_data     = 32'h10101010;
    bus.control         = 2'b00;
    bus.classify_enable = 1'b1;
    step();
    bus.classify_enable = 1'b0;
    step(); step(); step();
    bus.sample_data     = 32'h0;
    bus.control         = 2'b00;
    bus.classify_enable = 1'b1;
    bus.train_we        = 1'b1;
    bus.train_addr      = 8'd5;
    bus.train_data      = 32'h0;
    bus.train_label     = 1'b1;
    step();
    bus.classify_enable = 1'b0;
    bus.train_we        = 1'b0;
    lat = 4;
    while (bus.classify_sample_done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    cls = bus.sample_classification;
    n_total++; if (lat !== LAT || cls !== exp) $display("FAIL busy_restart lat=%0d cls=%b exp_lat=%0d exp_cls=%b", lat, cls, LAT, exp); else n_pass++;
    step();
    run_classify(32'h10101010, 2'b00, lat, cls, exp);
    step();
    n_total++; if (cls !== 1'b0 || exp !== 1'b0) $display("FAIL busy_write cls=%b model=%b exp=0", cls, exp); else n_pass++;
  endtask

  task automatic test_abort_and_init();
    int lat; logic cls, exp;
    bit seen;
    run_classify(32'h0, 2'b11, lat, cls, exp);
    step();
    bus.sample_data     = 32'h0;
    bus.control         = 2'b11;
    bus.classify_enable = 1'b1;
    step();
    bus.classify_enable = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cnt = 0;
    n_total++; if (bus.sample_classification !== 1'b0 || bus.count !== 11'd0)
      $display("FAIL abort_outputs cls=%b count=%0d exp=0/0", bus.sample_classification, bus.count);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.classify_sample_done === 1'b1) seen = 1;
      step();
    end
    n_total++; if (seen) $display("FAIL abort_done got=1 exp=0"); else n_pass++;
    run_classify(32'h0, 2'b11, lat, cls, exp);
    step();
    n_total++; if (bus.count !== 11'd1) $display("FAIL pre_init_count got=%0d exp=1", bus.count); else n_pass++;
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    m_cnt = 0;
    n_total++; if (bus.count !== 11'd0) $display("FAIL init_count got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat; logic cls, exp;
    int bad = 0;
    for (int i = 0; i < 2050; i++) begin
      run_classify(32'h0, 2'b11, lat, cls, exp);
      if (lat !== LAT || cls !== 1'b1) bad++;
      step();
    end
    n_total++; if (bad != 0) $display("FAIL sat_runs bad=%0d exp=0", bad); else n_pass++;
    n_total++; if (bus.count !== CW'(m_cnt) || m_cnt != 2047)
      $display("FAIL sat_count got=%0d exp=%0d", bus.count, m_cnt);
    else n_pass++;
    run_classify(32'h0, 2'b11, lat, cls, exp);
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    m_cnt = 0;
    n_total++; if (bus.count !== 11'd0) $display("FAIL init_priority got=%0d exp=0", bus.count); else n_pass++;
  endtask

  initial begin
    bus.control         = 2'b00;
    bus.sample_data     = 32'h0;
    bus.classify_enable = 1'b0;
    bus.train_we        = 1'b0;
    bus.train_addr      = 8'h0;
    bus.train_data      = 32'h0;
    bus.train_label     = 1'b0;
    bus.init            = 1'b0;
    test_reset();
    test_k1_nearest();
    test_k7_majority();
    test_tie();
    test_k3_k5();
    test_random(1'b0);
    test_random(1'b1);
    test_ignore_busy();
    test_abort_and_init();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
